// File: rtl/fetch_pkg.sv
// Shared types and widths for the Redux-V fetch stage.
package fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, reads instruction memory and presents one
// registered instruction per cycle to decode over a valid/ready handshake.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                INSTR_W  = fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt_req,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               running,
    output logic [CNT_W-1:0]   fetch_count
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic              slot_free;
    logic              fetch_en;
    logic              deliver;

    assign imem_addr = pc;
    assign running   = (state == RUN);
    assign slot_free = !out_valid || out_ready;

    // Redirect and halt both suppress the fetch; a redirect also voids any handshake.
    assign fetch_en = (state == RUN) && slot_free && !redirect_valid && !halt_req;
    assign deliver  = out_valid && out_ready && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !halt_req) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid || out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (redirect_valid) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
        end else if (fetch_en) begin
            out_instr <= imem_data;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + 1'b1;
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (deliver && (fetch_count != {CNT_W{1'b1}})) begin
            fetch_count <= fetch_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed vector table plus randomized run against a behavioural fetch model.
module tb_fetch_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [7:0]  imem_addr;
    logic [7:0]  imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_instr;
    logic [7:0]  out_pc;
    logic        running;
    logic [15:0] fetch_count;

    logic [7:0]  mem [256];

    int vectors;
    int miscompares;

    typedef struct {
        logic        st;
        logic        h;
        logic        rv;
        logic [7:0]  rpc;
        logic        rdy;
        logic        v;
        logic [7:0]  ins;
        logic [7:0]  p;
        logic        run;
        logic [15:0] cnt;
        logic [7:0]  addr;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: mode 0 = idle, 1 = fetching, 2 = draining.
    int          m_mode;
    int          m_pc;
    bit          m_valid;
    logic [7:0]  m_instr;
    int          m_opc;
    int          m_count;

    fetch_controller #(
        .ADDR_W  (8),
        .INSTR_W (8),
        .RESET_PC(8'h00)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .halt_req      (halt_req),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .running       (running),
        .fetch_count   (fetch_count)
    );

    assign imem_data = mem[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(input logic st, input logic h, input logic rv,
                                input logic [7:0] rpc, input logic rdy,
                                input logic v, input logic [7:0] ins, input logic [7:0] p,
                                input logic run, input logic [15:0] cnt, input logic [7:0] addr);
        vec_t r;
        r.st = st; r.h = h; r.rv = rv; r.rpc = rpc; r.rdy = rdy;
        r.v = v; r.ins = ins; r.p = p; r.run = run; r.cnt = cnt; r.addr = addr;
        vecs.push_back(r);
    endfunction

    task automatic apply_stimulus(input logic st, input logic h, input logic rv,
                                  input logic [7:0] rpc, input logic rdy);
        start          = st;
        halt_req       = h;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic ev, input logic [7:0] ei,
                                input logic [7:0] ep, input logic er, input logic [15:0] ec,
                                input logic [7:0] ea);
        bit bad;
        bad = (out_valid !== ev) || (running !== er) || (fetch_count !== ec) ||
              (imem_addr !== ea);
        if (ev && ((out_instr !== ei) || (out_pc !== ep))) begin
            bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL %s: got valid=%b instr=%h pc=%h running=%b count=%0d addr=%h, want valid=%b instr=%h pc=%h running=%b count=%0d addr=%h",
                     name, out_valid, out_instr, out_pc, running, fetch_count, imem_addr,
                     ev, ei, ep, er, ec, ea);
        end
    endtask

    // Advance the model by one clock edge using the rules of the fetch stage.
    task automatic model_step(input logic st, input logic h, input logic rv,
                              input logic [7:0] rpc, input logic rdy);
        bit was_valid;
        bit deliver;
        bit take;
        was_valid = m_valid;
        deliver   = m_valid && rdy && !rv;
        take      = (m_mode == 1) && (!m_valid || rdy) && !rv && !h;
        if (deliver && m_count < 65535) begin
            m_count = m_count + 1;
        end
        if (rv) begin
            m_pc    = int'(rpc);
            m_valid = 1'b0;
        end else if (take) begin
            m_instr = mem[m_pc];
            m_opc   = m_pc;
            m_valid = 1'b1;
            m_pc    = (m_pc + 1) % 256;
        end else if (deliver) begin
            m_valid = 1'b0;
        end
        if (m_mode == 0) begin
            if (st && !h) m_mode = 1;
        end else if (m_mode == 1) begin
            if (h) m_mode = 2;
        end else begin
            if (!was_valid || rdy) m_mode = 0;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n          = 1'b0;
        start          = 1'b0;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        out_ready      = 1'b0;
        for (int a = 0; a < 256; a++) begin
            mem[a] = 8'(8'hB0 + 5 * a);
        end
        mem[20] = 8'h45;

        //   st h rv rpc    rdy | v ins    pc     run cnt addr
        add(1, 0, 0, 8'h00, 1,   0, 8'h00, 8'h00, 1,  0, 8'h00);
        add(0, 0, 0, 8'h00, 1,   1, 8'hB0, 8'h00, 1,  0, 8'h01);
        add(0, 0, 0, 8'h00, 1,   1, 8'hB5, 8'h01, 1,  1, 8'h02);
        add(0, 0, 0, 8'h00, 1,   1, 8'hBA, 8'h02, 1,  2, 8'h03);
        add(0, 0, 0, 8'h00, 1,   1, 8'hBF, 8'h03, 1,  3, 8'h04);
        add(0, 0, 0, 8'h00, 0,   1, 8'hBF, 8'h03, 1,  3, 8'h04);
        add(0, 0, 0, 8'h00, 0,   1, 8'hBF, 8'h03, 1,  3, 8'h04);
        add(0, 0, 0, 8'h00, 0,   1, 8'hBF, 8'h03, 1,  3, 8'h04);
        add(0, 0, 0, 8'h00, 1,   1, 8'hC4, 8'h04, 1,  4, 8'h05);
        add(0, 0, 1, 8'h14, 1,   0, 8'h00, 8'h00, 1,  4, 8'h14);
        add(0, 0, 0, 8'h00, 1,   1, 8'h45, 8'h14, 1,  4, 8'h15);
        add(0, 0, 0, 8'h00, 1,   1, 8'h19, 8'h15, 1,  5, 8'h16);
        add(0, 0, 1, 8'hFE, 1,   0, 8'h00, 8'h00, 1,  5, 8'hFE);
        add(0, 0, 0, 8'h00, 1,   1, 8'hA6, 8'hFE, 1,  5, 8'hFF);
        add(0, 0, 0, 8'h00, 1,   1, 8'hAB, 8'hFF, 1,  6, 8'h00);
        add(0, 0, 0, 8'h00, 1,   1, 8'hB0, 8'h00, 1,  7, 8'h01);
        add(0, 0, 0, 8'h00, 1,   1, 8'hB5, 8'h01, 1,  8, 8'h02);
        add(0, 1, 0, 8'h00, 0,   1, 8'hB5, 8'h01, 0,  8, 8'h02);
        add(0, 0, 0, 8'h00, 0,   1, 8'hB5, 8'h01, 0,  8, 8'h02);
        add(0, 0, 0, 8'h00, 1,   0, 8'h00, 8'h00, 0,  9, 8'h02);
        add(0, 0, 0, 8'h00, 1,   0, 8'h00, 8'h00, 0,  9, 8'h02);
        add(1, 1, 0, 8'h00, 1,   0, 8'h00, 8'h00, 0,  9, 8'h02);
        add(0, 0, 0, 8'h00, 1,   0, 8'h00, 8'h00, 0,  9, 8'h02);
        add(0, 0, 1, 8'h10, 1,   0, 8'h00, 8'h00, 0,  9, 8'h10);
        add(1, 0, 0, 8'h00, 1,   0, 8'h00, 8'h00, 1,  9, 8'h10);
        add(0, 0, 0, 8'h00, 1,   1, 8'h00, 8'h10, 1,  9, 8'h11);
        add(0, 1, 1, 8'h30, 1,   0, 8'h00, 8'h00, 0,  9, 8'h30);
        add(0, 0, 0, 8'h00, 0,   0, 8'h00, 8'h00, 0,  9, 8'h30);
        add(1, 0, 0, 8'h00, 0,   0, 8'h00, 8'h00, 1,  9, 8'h30);
        add(0, 0, 0, 8'h00, 0,   1, 8'hA0, 8'h30, 1,  9, 8'h31);
        add(0, 0, 0, 8'h00, 1,   1, 8'hA5, 8'h31, 1, 10, 8'h32);

        #2;
        check_output("reset", 1'b0, 8'h00, 8'h00, 1'b0, 16'd0, 8'h00);
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].st, vecs[i].h, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            check_output($sformatf("row%0d", i), vecs[i].v, vecs[i].ins, vecs[i].p,
                         vecs[i].run, vecs[i].cnt, vecs[i].addr);
        end

        // Asynchronous reset between edges while an instruction is in flight.
        #3;
        rst_n = 1'b0;
        #1;
        check_output("async_reset", 1'b0, 8'h00, 8'h00, 1'b0, 16'd0, 8'h00);
        for (int a = 0; a < 256; a++) begin
            mem[a] = 8'($urandom);
        end
        #1;
        rst_n = 1'b1;

        m_mode  = 0;
        m_pc    = 0;
        m_valid = 1'b0;
        m_instr = 8'h00;
        m_opc   = 0;
        m_count = 0;
        for (int n = 0; n < 1500; n++) begin
            logic       st;
            logic       h;
            logic       rv;
            logic [7:0] rpc;
            logic       rdy;
            st  = ($urandom_range(0, 3) == 0);
            h   = ($urandom_range(0, 15) == 0);
            rv  = ($urandom_range(0, 11) == 0);
            rpc = 8'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            model_step(st, h, rv, rpc, rdy);
            apply_stimulus(st, h, rv, rpc, rdy);
            check_output($sformatf("rand%0d", n), m_valid, m_instr, 8'(m_opc),
                         (m_mode == 1), 16'(m_count), 8'(m_pc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
